// File: rtl/rca_config_pkg.sv
// Shared types and sizing for the RCA configuration bank.
// Optional even parity on active words: RCA_CFG_PARITY_EN.
package rca_config;

    localparam int NUM_RCAS     = 4;
    localparam int CFG_WORDS    = 16;
    localparam int CFG_WIDTH    = 8;
    localparam int MAX_INFLIGHT = 7;

    localparam int RCA_W  = $clog2(NUM_RCAS);
    localparam int ADDR_W = $clog2(CFG_WORDS);
    localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);

    typedef logic [RCA_W-1:0]     rca_id_t;
    typedef logic [ADDR_W-1:0]    cfg_addr_t;
    typedef logic [CFG_WIDTH-1:0] cfg_word_t;
    typedef logic [CNT_W-1:0]     cnt_t;
    typedef cfg_word_t [CFG_WORDS-1:0] cfg_set_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COPY
    } commit_state_t;

    function automatic logic even_par(cfg_word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/rca_inflight_counter.sv
// Saturating up/down in-flight counter for one RCA.
// err pulses for one cycle on overflow or underflow.
module rca_inflight_counter
    import rca_config::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output cnt_t count,
    output logic err
);

    localparam cnt_t CNT_MAX = cnt_t'(MAX_INFLIGHT);

    logic up;
    logic dn;

    assign up  = inc && !dec;
    assign dn  = dec && !inc;
    assign err = (up && count == CNT_MAX) || (dn && count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (up && count != CNT_MAX) begin
            count <= count + 1'b1;
        end else if (dn && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/rca_config_bank.sv
// Double-buffered RCA config store with drain-then-copy commit.
// Optional per-word even parity on the active set: RCA_CFG_PARITY_EN.
module rca_config_bank
    import rca_config::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [RCA_W-1:0]               wr_rca,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [CFG_WIDTH-1:0]           wr_data,
    input  logic                           commit_req,
    input  logic [RCA_W-1:0]               commit_rca,
    output logic                           commit_ready,
    output logic                           commit_ack,
    input  logic                           issue_valid,
    input  logic [RCA_W-1:0]               issue_rca,
    output logic                           issue_stall,
    input  logic                           retire_valid,
    input  logic [RCA_W-1:0]               retire_rca,
    input  logic [RCA_W-1:0]               rd_rca,
    output logic [CFG_WORDS*CFG_WIDTH-1:0] rd_cfg,
    output logic                           rd_cfg_valid,
    input  logic [RCA_W-1:0]               rb_rca,
    input  logic [ADDR_W-1:0]              rb_addr,
    input  logic                           rb_shadow,
    output logic [CFG_WIDTH-1:0]           rb_data,
    output logic                           inflight_err,
    output logic                           cfg_parity_err
);

    cfg_set_t      shadow_q [NUM_RCAS];
    cfg_set_t      active_q [NUM_RCAS];
    logic [NUM_RCAS-1:0] valid_q;
    commit_state_t state_q;
    commit_state_t state_d;
    rca_id_t       crca_q;
    logic          ack_q;
    cfg_word_t     rb_q;
    logic          err_q;

    cnt_t                inflight [NUM_RCAS];
    logic [NUM_RCAS-1:0] cnt_err;

    assign issue_stall = (state_q != ST_IDLE) && (issue_rca == crca_q);

    for (genvar i = 0; i < NUM_RCAS; i++) begin : g_cnt
        logic inc;
        logic dec;
        assign inc = issue_valid && !issue_stall
                  && (issue_rca == rca_id_t'(i));
        assign dec = retire_valid && (retire_rca == rca_id_t'(i));
        rca_inflight_counter u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc),
            .dec   (dec),
            .count (inflight[i]),
            .err   (cnt_err[i])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (commit_req) begin
                    state_d = (inflight[commit_rca] == '0)
                            ? ST_COPY : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight[crca_q] == '0) state_d = ST_COPY;
            end
            ST_COPY: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            crca_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_q == ST_COPY);
            err_q   <= err_q | (|cnt_err);
            if (state_q == ST_IDLE && commit_req) crca_q <= commit_rca;
        end
    end

    // Nonblocking copy sees the pre-write shadow on a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_RCAS; r++) begin
                shadow_q[r] <= '0;
                active_q[r] <= '0;
            end
            valid_q <= '0;
            rb_q    <= '0;
        end else begin
            if (wr_en) shadow_q[wr_rca][wr_addr] <= wr_data;
            if (state_q == ST_COPY) begin
                active_q[crca_q] <= shadow_q[crca_q];
                valid_q[crca_q]  <= 1'b1;
            end
            rb_q <= rb_shadow ? shadow_q[rb_rca][rb_addr]
                              : active_q[rb_rca][rb_addr];
        end
    end

`ifdef RCA_CFG_PARITY_EN
    logic [CFG_WORDS-1:0] par_q [NUM_RCAS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_RCAS; r++) par_q[r] <= '0;
        end else if (state_q == ST_COPY) begin
            for (int w = 0; w < CFG_WORDS; w++) begin
                par_q[crca_q][w] <= even_par(shadow_q[crca_q][w]);
            end
        end
    end

    always_comb begin
        cfg_parity_err = 1'b0;
        for (int w = 0; w < CFG_WORDS; w++) begin
            cfg_parity_err = cfg_parity_err
                | (even_par(active_q[rd_rca][w]) ^ par_q[rd_rca][w]);
        end
    end
`else
    assign cfg_parity_err = 1'b0;
`endif

    assign commit_ready = (state_q == ST_IDLE);
    assign commit_ack   = ack_q;
    assign rd_cfg       = active_q[rd_rca];
    assign rd_cfg_valid = valid_q[rd_rca];
    assign rb_data      = rb_q;
    assign inflight_err = err_q;

endmodule

// File: tb/tb_rca_config_bank.sv
// Directed self-checking bench for rca_config_bank.
module tb_rca_config_bank;
    import rca_config::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_en;
    logic [1:0]     wr_rca;
    logic [3:0]     wr_addr;
    logic [7:0]     wr_data;
    logic           commit_req;
    logic [1:0]     commit_rca;
    logic           commit_ready;
    logic           commit_ack;
    logic           issue_valid;
    logic [1:0]     issue_rca;
    logic           issue_stall;
    logic           retire_valid;
    logic [1:0]     retire_rca;
    logic [1:0]     rd_rca;
    logic [127:0]   rd_cfg;
    logic           rd_cfg_valid;
    logic [1:0]     rb_rca;
    logic [3:0]     rb_addr;
    logic           rb_shadow;
    logic [7:0]     rb_data;
    logic           inflight_err;
    logic           cfg_parity_err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rca_config_bank dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_rca         (wr_rca),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .commit_rca     (commit_rca),
        .commit_ready   (commit_ready),
        .commit_ack     (commit_ack),
        .issue_valid    (issue_valid),
        .issue_rca      (issue_rca),
        .issue_stall    (issue_stall),
        .retire_valid   (retire_valid),
        .retire_rca     (retire_rca),
        .rd_rca         (rd_rca),
        .rd_cfg         (rd_cfg),
        .rd_cfg_valid   (rd_cfg_valid),
        .rb_rca         (rb_rca),
        .rb_addr        (rb_addr),
        .rb_shadow      (rb_shadow),
        .rb_data        (rb_data),
        .inflight_err   (inflight_err),
        .cfg_parity_err (cfg_parity_err)
    );

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] r, input logic [3:0] a,
                      input logic [7:0] d);
        wr_en = 1'b1; wr_rca = r; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_rca = '0; wr_addr = '0;
        wr_data = '0; commit_req = 1'b0; commit_rca = '0;
        issue_valid = 1'b0; issue_rca = '0; retire_valid = 1'b0;
        retire_rca = '0; rd_rca = '0; rb_rca = '0; rb_addr = '0;
        rb_shadow = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_ready", commit_ready, 1);
        chk("rst_ack", commit_ack, 0);
        chk("rst_rb", rb_data, 0);
        chk("rst_err", inflight_err, 0);
        chk("rst_valid", rd_cfg_valid, 0);
        chk("rst_cfg", rd_cfg, 0);
        chk("rst_perr", cfg_parity_err, 0);

        // idle commit of RCA1: ack two cycles after request
        wr(2'd1, 4'd3, 8'hA5);
        commit_req = 1'b1; commit_rca = 2'd1;
        tick();
        commit_req = 1'b0;
        chk("c1_ack_cyc1", commit_ack, 0);
        chk("c1_ready_cyc1", commit_ready, 0);
        tick();
        chk("c1_ack_cyc2", commit_ack, 1);
        chk("c1_ready_cyc2", commit_ready, 1);
        tick();
        chk("c1_ack_drop", commit_ack, 0);
        rd_rca = 2'd1; #1;
        chk("c1_word3", rd_cfg[24 +: 8], 8'hA5);
        chk("c1_valid", rd_cfg_valid, 1);
        rd_rca = 2'd0; #1;
        chk("c0_valid", rd_cfg_valid, 0);

        // drain commit of RCA2
        wr(2'd2, 4'd5, 8'h5C);
        issue_valid = 1'b1; issue_rca = 2'd2;
        repeat (3) tick();
        issue_valid = 1'b0;
        chk("c2_cnt3", dut.inflight[2], 3);
        commit_req = 1'b1; commit_rca = 2'd2;
        tick();
        commit_req = 1'b0;
        chk("c2_drain_ready", commit_ready, 0);
        issue_rca = 2'd2; #1;
        chk("c2_stall_2", issue_stall, 1);
        issue_rca = 2'd1; #1;
        chk("c2_stall_1", issue_stall, 0);
        issue_valid = 1'b1; issue_rca = 2'd2;
        tick();
        issue_valid = 1'b0;
        chk("c2_stalled_issue", dut.inflight[2], 3);
        retire_valid = 1'b1; retire_rca = 2'd2;
        repeat (3) tick();
        retire_valid = 1'b0;
        chk("c2_cnt0", dut.inflight[2], 0);
        chk("c2_ack_early", commit_ack, 0);
        tick();
        // this cycle is COPY: write the same RCA and read it back
        chk("c2_ack_copy", commit_ack, 0);
        wr_en = 1'b1; wr_rca = 2'd2; wr_addr = 4'd0; wr_data = 8'h11;
        rb_rca = 2'd2; rb_addr = 4'd0; rb_shadow = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("c2_ack", commit_ack, 1);
        chk("rb_prewrite", rb_data, 8'h00);
        tick();
        chk("rb_shadow_new", rb_data, 8'h11);
        rd_rca = 2'd2; #1;
        chk("c2_word0_old", rd_cfg[0 +: 8], 8'h00);
        chk("c2_word5", rd_cfg[40 +: 8], 8'h5C);
        chk("c2_valid", rd_cfg_valid, 1);
        rb_shadow = 1'b0;
        tick();
        chk("rb_active0", rb_data, 8'h00);
        rb_addr = 4'd5;
        tick();
        chk("rb_active5", rb_data, 8'h5C);

        // saturation of RCA0
        issue_valid = 1'b1; issue_rca = 2'd0;
        repeat (7) tick();
        chk("sat_cnt7", dut.inflight[0], 7);
        chk("sat_err0", inflight_err, 0);
        tick();
        issue_valid = 1'b0;
        chk("sat_cnt_hold", dut.inflight[0], 7);
        chk("sat_err1", inflight_err, 1);
        repeat (3) tick();
        chk("sat_err_sticky", inflight_err, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("sat_err_rst", inflight_err, 0);
        retire_valid = 1'b1; retire_rca = 2'd3;
        tick();
        retire_valid = 1'b0;
        chk("under_cnt", dut.inflight[3], 0);
        chk("under_err", inflight_err, 1);
        tick();
        chk("under_sticky", inflight_err, 1);

        // reset in DRAIN abandons the copy
        wr(2'd1, 4'd0, 8'h77);
        commit_req = 1'b1; commit_rca = 2'd1;
        tick();
        commit_req = 1'b0;
        tick();
        chk("d_pre_ack", commit_ack, 1);
        wr(2'd1, 4'd0, 8'h66);
        issue_valid = 1'b1; issue_rca = 2'd1;
        repeat (2) tick();
        issue_valid = 1'b0;
        commit_req = 1'b1; commit_rca = 2'd1;
        tick();
        commit_req = 1'b0;
        rd_rca = 2'd1; #1;
        chk("d_in_drain", commit_ready, 0);
        chk("d_active_pre", rd_cfg[0 +: 8], 8'h77);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("d_ready", commit_ready, 1);
        chk("d_noack", commit_ack, 0);
        chk("d_cfg_zero", rd_cfg, 0);
        chk("d_valid0", rd_cfg_valid, 0);
        tick();
        chk("d_noack2", commit_ack, 0);

`ifdef RCA_CFG_PARITY_EN
        wr(2'd3, 4'd2, 8'h0F);
        commit_req = 1'b1; commit_rca = 2'd3;
        tick();
        commit_req = 1'b0;
        tick();
        rd_rca = 2'd3; #1;
        chk("p_clean", cfg_parity_err, 0);
        force dut.active_q[3][2][0] = 1'b0;
        #1;
        chk("p_flip", cfg_parity_err, 1);
        rd_rca = 2'd0; #1;
        chk("p_other", cfg_parity_err, 0);
        release dut.active_q[3][2][0];
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
